// File: rtl/store_buffer.sv
// Store buffer: forms byte-lane data/masks for sb/sh/sw/sd, queues them in a FIFO and drains to the D-cache.
// Optional STORE_COALESCE_EN: merge a store into the tail-most non-head entry with the same aligned address.
module store_buffer #(
  parameter int ADDRESS_WIDTH          = 64,
  parameter int REGISTER_WIDTH         = 64,
  parameter int INSTRUCTION_NAME_WIDTH = 96,
  parameter int DEPTH                  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_enable,
  input  logic [INSTRUCTION_NAME_WIDTH-1:0] in_opcode_name,
  input  logic [ADDRESS_WIDTH-1:0]          in_addr,
  input  logic [REGISTER_WIDTH-1:0]         in_rs2_value,
  output logic                              out_ready,
  output logic                              out_misaligned,
  output logic                              out_wr_en,
  output logic [ADDRESS_WIDTH-1:0]          out_wr_addr,
  output logic [REGISTER_WIDTH-1:0]         out_wr_data,
  output logic [7:0]                        out_wr_mask,
  input  logic                              in_wr_done,
  input  logic [ADDRESS_WIDTH-1:0]          in_ld_addr,
  output logic                              out_ld_conflict,
  input  logic                              in_flush,
  output logic                              out_flush_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_SB = "sb";
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_SH = "sh";
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_SW = "sw";
  localparam logic [INSTRUCTION_NAME_WIDTH-1:0] OP_SD = "sd";

  logic [ADDRESS_WIDTH-1:0]  addr_q [DEPTH];
  logic [REGISTER_WIDTH-1:0] data_q [DEPTH];
  logic [7:0]                mask_q [DEPTH];
  logic [DEPTH-1:0]          valid_q;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_pending_q, flush_pending_d;
  logic             misaligned_q, misaligned_d;
  logic             flush_done_q, flush_done_d;

  logic                      is_store, aligned, full, accept, do_pop, do_alloc, do_merge, flush_req;
  logic [2:0]                off;
  logic [7:0]                st_mask;
  logic [REGISTER_WIDTH-1:0] st_data;
  logic [ADDRESS_WIDTH-1:0]  st_addr;
  logic                      unused_ld_lsbs;

  assign off     = in_addr[2:0];
  assign st_data = in_rs2_value << {off, 3'b000};
  assign st_addr = {in_addr[ADDRESS_WIDTH-1:3], 3'b000};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    is_store = 1'b0;
    aligned  = 1'b0;
    st_mask  = 8'h00;
    if (in_opcode_name == OP_SB) begin
      is_store = 1'b1; aligned = 1'b1;             st_mask = 8'h01 << off;
    end else if (in_opcode_name == OP_SH) begin
      is_store = 1'b1; aligned = ~off[0];          st_mask = 8'h03 << off;
    end else if (in_opcode_name == OP_SW) begin
      is_store = 1'b1; aligned = (off[1:0] == 2'b00); st_mask = 8'h0F << off;
    end else if (in_opcode_name == OP_SD) begin
      is_store = 1'b1; aligned = (off == 3'b000);  st_mask = 8'hFF;
    end
    is_store = is_store & in_enable;
  end

  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_ready = ~(is_store & (full | flush_pending_q));
  assign accept    = is_store & out_ready & aligned;
  assign do_pop    = in_wr_done & (count_q != '0);

`ifdef STORE_COALESCE_EN
  logic [PTR_W-1:0]          tail_last;
  logic [REGISTER_WIDTH-1:0] merge_data;
  assign tail_last = tail_q - 1'b1;
  // With two or more entries the tail-most one is never the head, so it cannot be popped mid-merge.
  assign do_merge  = accept & (count_q >= CNT_W'(2)) &
                     (addr_q[tail_last][ADDRESS_WIDTH-1:3] == in_addr[ADDRESS_WIDTH-1:3]);
  always_comb begin
    merge_data = data_q[tail_last];
    for (int b = 0; b < 8; b++) begin
      if (st_mask[b]) merge_data[8*b +: 8] = st_data[8*b +: 8];
    end
  end
`else
  assign do_merge = 1'b0;
`endif

  assign do_alloc = accept & ~do_merge;

  // An in_flush on an already-empty buffer completes on the very next edge.
  assign flush_req = flush_pending_q | in_flush;

  always_comb begin
    head_d          = head_q + PTR_W'(do_pop);
    tail_d          = tail_q + PTR_W'(do_alloc);
    count_d         = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
    misaligned_d    = is_store & out_ready & ~aligned;
    flush_done_d    = flush_req & (count_q == '0) & ~do_alloc;
    flush_pending_d = flush_req & ~flush_done_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      flush_pending_q <= 1'b0;
      misaligned_q    <= 1'b0;
      flush_done_q    <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      flush_pending_q <= flush_pending_d;
      misaligned_q    <= misaligned_d;
      flush_done_q    <= flush_done_d;
    end
  end

  // NOTE: the entry array is reset as well so the head-driven write port reads all-zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      if (do_pop) valid_q[head_q] <= 1'b0;
      if (do_alloc) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= st_addr;
        data_q[tail_q]  <= st_data;
        mask_q[tail_q]  <= st_mask;
      end
`ifdef STORE_COALESCE_EN
      if (do_merge) begin
        data_q[tail_last] <= merge_data;
        mask_q[tail_last] <= mask_q[tail_last] | st_mask;
      end
`endif
    end
  end

  always_comb begin
    out_ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][ADDRESS_WIDTH-1:3] == in_ld_addr[ADDRESS_WIDTH-1:3]))
        out_ld_conflict = 1'b1;
    end
  end

  assign unused_ld_lsbs = ^in_ld_addr[2:0];

  assign out_wr_en      = (count_q != '0);
  assign out_wr_addr    = addr_q[head_q];
  assign out_wr_data    = data_q[head_q];
  assign out_wr_mask    = mask_q[head_q];
  assign out_misaligned = misaligned_q;
  assign out_flush_done = flush_done_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: lanes, misalignment, fill/drain, conflict, flush, coalesce.
module tb_store_buffer;
  localparam int AW = 64;
  localparam int RW = 64;
  localparam int IW = 96;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_enable;
  logic [IW-1:0] in_opcode_name;
  logic [AW-1:0] in_addr;
  logic [RW-1:0] in_rs2_value;
  logic          out_ready;
  logic          out_misaligned;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic [RW-1:0] out_wr_data;
  logic [7:0]    out_wr_mask;
  logic          in_wr_done;
  logic [AW-1:0] in_ld_addr;
  logic          out_ld_conflict;
  logic          in_flush;
  logic          out_flush_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  store_buffer #(
    .ADDRESS_WIDTH(AW), .REGISTER_WIDTH(RW), .INSTRUCTION_NAME_WIDTH(IW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .in_opcode_name(in_opcode_name),
    .in_addr(in_addr), .in_rs2_value(in_rs2_value), .out_ready(out_ready),
    .out_misaligned(out_misaligned), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data), .out_wr_mask(out_wr_mask), .in_wr_done(in_wr_done),
    .in_ld_addr(in_ld_addr), .out_ld_conflict(out_ld_conflict), .in_flush(in_flush),
    .out_flush_done(out_flush_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [IW-1:0] name, input logic [AW-1:0] addr, input logic [RW-1:0] data);
    in_enable      = 1'b1;
    in_opcode_name = name;
    in_addr        = addr;
    in_rs2_value   = data;
    #1;
  endtask

  task automatic idle();
    in_enable      = 1'b0;
    in_opcode_name = "nop";
    in_addr        = '0;
    in_rs2_value   = '0;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_wr_done = 1'b0; in_ld_addr = '0; in_flush = 1'b0;
    idle();
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_wr_en", out_wr_en, 0);
    check("rst_wr_addr", out_wr_addr, 0);
    check("rst_wr_data", out_wr_data, 0);
    check("rst_wr_mask", out_wr_mask, 0);
    check("rst_misaligned", out_misaligned, 0);
    check("rst_flush_done", out_flush_done, 0);
    check("rst_ld_conflict", out_ld_conflict, 0);
    check("rst_ready", out_ready, 1);

    // sb with upper garbage: shifted by 40, truncated to 64 bits
    op("sb", 64'h1005, 64'h1122334455_6677AB);
    check("sb_ready", out_ready, 1);
    step(); idle();
    check("sb_wr_en", out_wr_en, 1);
    check("sb_addr", out_wr_addr, 64'h1000);
    check("sb_mask", out_wr_mask, 8'h20);
    check("sb_data", out_wr_data, 64'h6677AB00_00000000);
    in_wr_done = 1'b1; step(); in_wr_done = 1'b0; #1;
    check("sb_popped", out_wr_en, 0);

    op("sw", 64'h2004, 64'hDEADBEEF);
    step(); idle();
    check("sw_addr", out_wr_addr, 64'h2000);
    check("sw_mask", out_wr_mask, 8'hF0);
    check("sw_data", out_wr_data, 64'hDEADBEEF_00000000);
    in_wr_done = 1'b1; step(); in_wr_done = 1'b0; #1;

    op("sh", 64'h3006, 64'hBEEF);
    step(); idle();
    check("sh_mask", out_wr_mask, 8'hC0);
    check("sh_data", out_wr_data, 64'hBEEF0000_00000000);
    in_wr_done = 1'b1; step(); in_wr_done = 1'b0; #1;
    check("sh_popped", out_wr_en, 0);

    // misaligned stores are consumed and dropped with a one-cycle pulse
    op("sh", 64'h3001, 64'h1234);
    check("mis_sh_ready", out_ready, 1);
    step(); idle();
    check("mis_sh_pulse", out_misaligned, 1);
    check("mis_sh_empty", out_wr_en, 0);
    step();
    check("mis_sh_pulse_end", out_misaligned, 0);
    op("sd", 64'h3004, 64'h5678);
    step(); idle();
    check("mis_sd_pulse", out_misaligned, 1);
    check("mis_sd_empty", out_wr_en, 0);
    step();
    check("mis_sd_pulse_end", out_misaligned, 0);

    // fill to DEPTH, then drain back-to-back
    for (int i = 0; i < DEPTH; i++) begin
      op("sd", 64'h100 + 64'(8 * i), 64'(i + 1));
      check("fill_ready", out_ready, 1);
      step();
    end
    op("sd", 64'h200, 64'h99);
    check("full_store_ready", out_ready, 0);
    op("ld", 64'h200, 64'h0);
    check("full_load_ready", out_ready, 1);
    idle();
    in_wr_done = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_en", out_wr_en, 1);
      check("drain_addr", out_wr_addr, 64'h100 + 64'(8 * i));
      check("drain_data", out_wr_data, 64'(i + 1));
      step();
    end
    in_wr_done = 1'b0; #1;
    check("drain_empty", out_wr_en, 0);

    // load conflict against valid entries only
    in_ld_addr = 64'h4000;
    op("sd", 64'h4000, 64'hCAFE);
    check("conflict_push_cycle", out_ld_conflict, 0);
    step(); idle();
    in_ld_addr = 64'h4006; #1;
    check("conflict_same_dword", out_ld_conflict, 1);
    in_ld_addr = 64'h4008; #1;
    check("conflict_next_dword", out_ld_conflict, 0);

    // reset mid-drain discards entries and ignores wr_done
    in_wr_done = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; in_wr_done = 1'b0; #1;
    check("midrst_wr_en", out_wr_en, 0);
    check("midrst_addr", out_wr_addr, 0);

    // flush with two entries queued
    op("sd", 64'h6000, 64'h1); step();
    op("sd", 64'h6008, 64'h2); step();
    idle();
    in_flush = 1'b1; step(); in_flush = 1'b0;
    op("sw", 64'h7000, 64'h3);
    check("flush_store_stall", out_ready, 0);
    op("ld", 64'h7000, 64'h0);
    check("flush_load_ready", out_ready, 1);
    idle();
    check("flush_not_done", out_flush_done, 0);
    in_wr_done = 1'b1;
    step(); step();
    in_wr_done = 1'b0; #1;
    check("flush_drained", out_wr_en, 0);
    check("flush_done_wait", out_flush_done, 0);
    step();
    check("flush_done_pulse", out_flush_done, 1);
    step();
    check("flush_done_end", out_flush_done, 0);
    op("sw", 64'h7000, 64'h3);
    check("flush_released", out_ready, 1);
    idle();

    in_flush = 1'b1; step(); in_flush = 1'b0; #1;
    check("flush_empty_pulse", out_flush_done, 1);
    step();
    check("flush_empty_end", out_flush_done, 0);

    // coalescing candidate sequence
    op("sb", 64'h5000, 64'h11); step();
    op("sb", 64'h5008, 64'h22); step();
    op("sb", 64'h5009, 64'h33); step();
    idle();
    in_wr_done = 1'b1;
    check("coal_head_addr", out_wr_addr, 64'h5000);
    step();
    check("coal_e1_addr", out_wr_addr, 64'h5008);
`ifdef STORE_COALESCE_EN
    check("coal_e1_mask", out_wr_mask, 8'h03);
    check("coal_e1_data", out_wr_data, 64'h3322);
    step();
    check("coal_count2_empty", out_wr_en, 0);
`else
    check("coal_e1_mask", out_wr_mask, 8'h01);
    check("coal_e1_data", out_wr_data, 64'h22);
    step();
    check("coal_e2_mask", out_wr_mask, 8'h02);
    check("coal_e2_data", out_wr_data, 64'h3300);
    step();
    check("coal_count3_empty", out_wr_en, 0);
`endif
    in_wr_done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
